prbs7_checker: RTL and testbench

Serial PRBS7 (x^7 + x^6 + 1) checker: the receive-side counterpart of the `prbs7_gen` pattern generator. It self-synchronises to an incoming PRBS7 bit stream, declares lock, then flags and counts bit errors. Loss of lock is declared on an error burst. It sits at the far end of a serial test link, or in loopback against `prbs7_gen`, for BER measurement.

---
 rtl/prbs_pkg.sv | 21 ++
 rtl/sat_counter.sv | 37 +++
 rtl/prbs7_checker.sv | 128 ++++++++++++
 tb/tb_prbs7_checker.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: definitions shared by the PRBS7 pattern generator and checker.
//   PRBS7_W          : width of the x^7 + x^6 + 1 history/state register
//   PRBS7_TAP_HI/LO  : history bits XORed to produce the next sequence bit
//   state_e          : checker lock state encoding
//   prbs7_predict()  : next expected bit given the last 7 bits (bit 0 newest)
package prbs_pkg;

  localparam int PRBS7_W      = 7;
  localparam int PRBS7_TAP_HI = 6;
  localparam int PRBS7_TAP_LO = 5;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  function automatic logic prbs7_predict(input logic [PRBS7_W-1:0] h);
    return h[PRBS7_TAP_HI] ^ h[PRBS7_TAP_LO];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   inc        : add one this cycle unless already saturated
//   clr        : synchronous clear, wins over inc
//   count      : registered count value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prbs7_checker.sv
// prbs7_checker: self-synchronising PRBS7 (x^7 + x^6 + 1) receive checker.
// Searches for the pattern by predicting each bit from the previous seven,
// declares lock after LOCK_CNT consecutive good predictions, then flags and
// counts mismatches. LOSS_ERRS errors inside one WINDOW-bit window drop lock.
//   clk, reset : clock, asynchronous active-high reset
//   din        : received serial bit, sampled when din_valid is high
//   din_valid  : qualifies din
//   clear_cnt  : synchronous clear of err_count (wins over an increment)
//   locked     : registered, high while locked
//   err        : registered one-cycle pulse per mismatched bit while locked
//   err_count  : registered saturating count of err pulses
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT  = 16,
  parameter int WINDOW    = 64,
  parameter int LOSS_ERRS = 4,
  parameter int COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               clear_cnt,
  output logic               locked,
  output logic               err,
  output logic [COUNT_W-1:0] err_count
);

  localparam int MATCH_W = 8;
  localparam int WIN_W   = $clog2(WINDOW + 1);

  state_e               state_q, state_d;
  logic [PRBS7_W-1:0]   h_q, h_d;
  logic [2:0]           fill_q, fill_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [WIN_W-1:0]     werr_q, werr_d;
  logic                 err_q, err_d;
  logic                 pred;
  logic                 mis;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    err_d   = 1'b0;
    pred    = prbs7_predict(h_q);
    mis     = (din != pred);

    if (din_valid) begin
      if (state_q == ST_SEARCH) begin
        h_d = {h_q[PRBS7_W-2:0], din};
        if (fill_q != 3'd7) begin
          fill_d = fill_q + 3'd1;
        end else begin
          // An all-zero history trivially predicts 0; refusing to count it
          // keeps a stuck-at-0 line from ever locking.
          if (!mis && (h_q != '0)) begin
            match_d = match_q + MATCH_W'(1);
          end else begin
            match_d = '0;
          end
          if (match_d == MATCH_W'(LOCK_CNT)) begin
            state_d = ST_LOCKED;
            win_d   = '0;
            werr_d  = '0;
          end
        end
      end else begin
        // Feed back the prediction, not din, so line errors never pollute
        // the history while locked.
        h_d    = {h_q[PRBS7_W-2:0], pred};
        err_d  = mis;
        win_d  = win_q + WIN_W'(1);
        werr_d = werr_q + WIN_W'(mis);
        if (werr_d == WIN_W'(LOSS_ERRS)) begin
          state_d = ST_SEARCH;
          h_d     = '0;
          fill_d  = '0;
          match_d = '0;
          win_d   = '0;
          werr_d  = '0;
        end else if (win_d == WIN_W'(WINDOW)) begin
          win_d  = '0;
          werr_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SEARCH;
      h_q     <= '0;
      fill_q  <= '0;
      match_q <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(
    .W(COUNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_d),
    .clr   (clear_cnt),
    .count (err_count)
  );

  assign locked = (state_q == ST_LOCKED);
  assign err    = err_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Scoreboard bench for prbs7_checker: stimulus pushes the expected outputs of a
// queue-based reference model; a monitor pops and compares every cycle.
module tb_prbs7_checker;

  localparam int LOCK_CNT  = 16;
  localparam int WINDOW    = 64;
  localparam int LOSS_ERRS = 4;
  localparam int COUNT_W   = 4;
  localparam int CNT_MAX   = (1 << COUNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               din = 1'b0;
  logic               din_valid = 1'b0;
  logic               clear_cnt = 1'b0;
  logic               locked;
  logic               err;
  logic [COUNT_W-1:0] err_count;

  prbs7_checker #(
    .LOCK_CNT (LOCK_CNT),
    .WINDOW   (WINDOW),
    .LOSS_ERRS(LOSS_ERRS),
    .COUNT_W  (COUNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .din_valid(din_valid),
    .clear_cnt(clear_cnt),
    .locked   (locked),
    .err      (err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit lk;
    bit er;
    int cnt;
  } exp_t;

  exp_t expq[$];

  int m_hist[$];   // last accepted bits, index 0 oldest
  bit m_locked;
  int m_match, m_win, m_werr, m_cnt;
  bit m_err;

  function automatic void model_reset();
    m_hist.delete();
    m_locked = 0;
    m_match  = 0;
    m_win    = 0;
    m_werr   = 0;
    m_cnt    = 0;
    m_err    = 0;
  endfunction

  function automatic void model_step(input bit v, input bit d, input bit clr);
    int p;
    int sum;
    m_err = 0;
    if (v) begin
      if (m_hist.size() == 7) p = m_hist[0] ^ m_hist[1];
      else p = 0;
      if (!m_locked) begin
        if (m_hist.size() == 7) begin
          sum = 0;
          foreach (m_hist[i]) sum += m_hist[i];
          if ((int'(d) == p) && (sum != 0)) m_match++;
          else m_match = 0;
        end
        m_hist.push_back(int'(d));
        if (m_hist.size() > 7) void'(m_hist.pop_front());
        if (m_match == LOCK_CNT) begin
          m_locked = 1;
          m_match  = 0;
          m_win    = 0;
          m_werr   = 0;
        end
      end else begin
        m_hist.push_back(p);
        void'(m_hist.pop_front());
        m_win++;
        if (int'(d) != p) begin
          m_err = 1;
          m_werr++;
        end
        if (m_werr == LOSS_ERRS) begin
          m_locked = 0;
          m_hist.delete();
          m_match = 0;
          m_win   = 0;
          m_werr  = 0;
        end else if (m_win == WINDOW) begin
          m_win  = 0;
          m_werr = 0;
        end
      end
    end
    if (clr) m_cnt = 0;
    else if (m_err && m_cnt < CNT_MAX) m_cnt++;
  endfunction

  // ---------------- stimulus ----------------
  logic [6:0] gen_s = 7'h7F;   // transmitter PRBS7 state, runs only on valid bits

  task automatic send_raw(input bit v, input bit d, input bit clr);
    exp_t e;
    @(negedge clk);
    din       = d;
    din_valid = v;
    clear_cnt = clr;
    model_step(v, d, clr);
    e.lk  = m_locked;
    e.er  = m_err;
    e.cnt = m_cnt;
    expq.push_back(e);
    @(posedge clk);
    #3;
  endtask

  task automatic send_gen(input bit v, input bit flip, input bit clr);
    bit b;
    if (v) begin
      b     = gen_s[6] ^ gen_s[5];
      gen_s = {gen_s[5:0], b};
      send_raw(1'b1, b ^ flip, clr);
    end else begin
      send_raw(1'b0, 1'($urandom_range(0, 1)), clr);
    end
  endtask

  task automatic do_reset(input int cycles);
    exp_t e;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err), 0);
    check("rst_count", int'(err_count), 0);
    e.lk = 0; e.er = 0; e.cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      clear_cnt = 1'b0;
      expq.push_back(e);
      @(posedge clk);
      #3;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("locked", int'(locked), int'(e.lk));
        check("err", int'(err), int'(e.er));
        check("err_count", int'(err_count), e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lock_at;
    int vcnt;
    bit seen_err, seen_lock;

    #2;
    do_reset(3);

    // Clean stream: lock exactly on the 23rd valid bit, no errors.
    lock_at = 0; seen_err = 0;
    for (int i = 1; i <= 500; i++) begin
      send_gen(1, 0, 0);
      if (lock_at == 0 && locked) lock_at = i;
      if (err) seen_err = 1;
    end
    check("lock_bit_clean", lock_at, 23);
    check("err_seen_clean", int'(seen_err), 0);
    check("count_clean", int'(err_count), 0);

    // Single flipped bit while locked.
    for (int i = 0; i < 99; i++) send_gen(1, 0, 0);
    send_gen(1, 1, 0);
    check("single_err", int'(err), 1);
    check("single_count", int'(err_count), 1);
    check("single_locked", int'(locked), 1);
    send_gen(1, 0, 0);
    check("single_err_pulse", int'(err), 0);

    // Error burst: four flips within 30 bits drops lock, then relock.
    do_reset(2);
    for (int i = 0; i < 28; i++) send_gen(1, 0, 0);
    check("burst_prelock", int'(locked), 1);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 7; j++) send_gen(1, 0, 0);
      send_gen(1, 1, 0);
      if (k < 3) check("burst_still_locked", int'(locked), 1);
    end
    check("burst_unlocked", int'(locked), 0);
    check("burst_err", int'(err), 1);
    check("burst_count", int'(err_count), 4);
    lock_at = 0;
    for (int i = 1; i <= 30; i++) begin
      send_gen(1, 0, 0);
      if (lock_at == 0 && locked) lock_at = i;
    end
    check("relock_bit", lock_at, 23);

    // Stuck-at-0 line never locks.
    do_reset(2);
    seen_lock = 0; seen_err = 0;
    for (int i = 0; i < 300; i++) begin
      send_raw(1, 0, 0);
      if (locked) seen_lock = 1;
      if (err) seen_err = 1;
    end
    check("zeros_locked", int'(seen_lock), 0);
    check("zeros_err", int'(seen_err), 0);

    // Alternating valid: lock counts valid bits only.
    do_reset(2);
    lock_at = 0; vcnt = 0;
    for (int c = 0; c < 60; c++) begin
      send_gen(c % 2 == 0, 0, 0);
      if (c % 2 == 0) vcnt++;
      if (lock_at == 0 && locked) lock_at = vcnt;
    end
    check("gap_lock_bit", lock_at, 23);
    check("gap_locked", int'(locked), 1);

    // Spaced errors saturate the counter without losing lock.
    for (int e = 0; e < 20; e++) begin
      for (int j = 0; j < 69; j++) send_gen(1, 0, 0);
      send_gen(1, 1, 0);
    end
    check("sat_count", int'(err_count), CNT_MAX);
    check("sat_locked", int'(locked), 1);
    send_gen(1, 0, 1);
    check("clear_count", int'(err_count), 0);
    send_gen(1, 1, 1);
    check("clear_vs_err_pulse", int'(err), 1);
    check("clear_vs_err_count", int'(err_count), 0);
    send_gen(1, 1, 0);
    check("post_clear_count", int'(err_count), 1);

    // Reset mid-lock with err high and a nonzero count.
    do_reset(2);

    // Randomised traffic checked cycle by cycle against the model.
    for (int i = 0; i < 800; i++) begin
      send_gen($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
               $urandom_range(0, 99) == 0);
    end

    @(negedge clk);
    check("queue_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
